// File: rtl/uart_rx_v2_if.sv
// Output-side handshake bundle for uart_rx_v2.
//
// The receiver drives the held word and its status flags. The consumer drives
// out_ready. A word transfers on any clock where out_valid && out_ready.
//   out_data  : received word, LSB = first bit on the line
//   out_valid : holding register full
//   out_ready : consumer accepts the held word
//   out_perr  : parity error for the held word
//   out_ferr  : framing error (a stop sample was 0) for the held word
//   out_brk   : break condition detected for the held word
interface uart_rx_v2_if #(
    parameter int D_W = 8
);
    logic [D_W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_perr;
    logic           out_ferr;
    logic           out_brk;

    modport master (
        output out_data,
        output out_valid,
        output out_perr,
        output out_ferr,
        output out_brk,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_perr,
        input  out_ferr,
        input  out_brk,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_v2.sv
// uart_rx_v2: oversampling UART receiver with an integrated baud tick
// divider, an rxd synchroniser, runtime parity/stop-bit modes, and a
// one-entry holding register with a valid/ready handshake.
//
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : receiver enable; 0 holds the divider and aborts any frame
//   dvsr       : baud divisor, tick period is dvsr+1 clocks
//   par_mode   : 00 none, 01 even, 10 odd, 11 none
//   stop2      : 1 selects two stop bits
//   rxd        : serial input, idles high
//   rx_out     : holding register handshake (uart_rx_v2_if master)
//   overrun    : sticky, set when a completed frame had to be dropped
//   clr_ovr    : synchronous clear of overrun
module uart_rx_v2 #(
    parameter int D_W         = 8,
    parameter int B_TICK      = 16,
    parameter int DVSR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    input  logic              rxd,
    uart_rx_v2_if.master      rx_out,
    output logic              overrun,
    input  logic              clr_ovr
);

    localparam int S_W = $clog2(B_TICK);
    localparam int N_W = $clog2(D_W) + 1;

    localparam logic [S_W-1:0] S_HALF = S_W'(B_TICK / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(B_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(D_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Baud tick divider
    // ------------------------------------------------------------------
    logic [DVSR_W-1:0] div_cnt;
    logic              tick;

    // The >= compare means lowering dvsr below the running count ends the
    // current period at once instead of wrapping through the full range.
    assign tick = en && (div_cnt >= dvsr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!en || (div_cnt >= dvsr)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // rxd synchroniser, reset to the idle (high) line level
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    state_t         state;
    logic [S_W-1:0] s_cnt;
    logic [N_W-1:0] n_cnt;
    logic [D_W-1:0] sh_q;
    logic           par_en_q;
    logic           par_odd_q;
    logic           stop2_q;
    logic           stop_idx_q;   // 0 while sampling the first stop bit
    logic           pbit_q;       // sampled parity bit
    logic           perr_q;
    logic           ferr_q;
    logic           brk_stop_q;   // first stop sample, kept for two-stop frames

    logic           s_last;
    logic           frame_done;
    logic           ferr_fin;
    logic           first_stop;
    logic           brk_fin;
    logic           par_calc;
    logic           perr_calc;

    assign s_last     = (s_cnt == S_LAST);
    assign frame_done = (state == ST_STOP) && tick && s_last &&
                        (!stop2_q || stop_idx_q);

    // Final status values include the stop sample taken in this very cycle.
    assign ferr_fin   = ferr_q | ~rxd_s;
    assign first_stop = stop_idx_q ? brk_stop_q : rxd_s;
    assign brk_fin    = (sh_q == '0) && (!par_en_q || !pbit_q) && !first_stop;

    assign par_calc   = (^sh_q) ^ rxd_s;
    assign perr_calc  = par_odd_q ? ~par_calc : par_calc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            s_cnt      <= '0;
            n_cnt      <= '0;
            sh_q       <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            pbit_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_stop_q <= 1'b0;
        end else if (!en) begin
            state <= ST_IDLE;
            s_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state <= ST_START;
                        s_cnt <= '0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (s_cnt == S_HALF) begin
                            if (!rxd_s) begin
                                // Mid start bit confirmed: latch the frame modes.
                                state      <= ST_DATA;
                                s_cnt      <= '0;
                                n_cnt      <= '0;
                                par_en_q   <= ^par_mode;
                                par_odd_q  <= (par_mode == 2'b10);
                                stop2_q    <= stop2;
                                stop_idx_q <= 1'b0;
                                pbit_q     <= 1'b0;
                                perr_q     <= 1'b0;
                                ferr_q     <= 1'b0;
                                brk_stop_q <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (s_last) begin
                            s_cnt <= '0;
                            sh_q  <= {rxd_s, sh_q[D_W-1:1]};
                            if (n_cnt == N_LAST) begin
                                state <= par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                n_cnt <= n_cnt + 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        if (s_last) begin
                            s_cnt  <= '0;
                            pbit_q <= rxd_s;
                            perr_q <= perr_calc;
                            state  <= ST_STOP;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (s_last) begin
                            s_cnt  <= '0;
                            ferr_q <= ferr_fin;
                            if (!stop2_q || stop_idx_q) begin
                                state <= ST_IDLE;
                            end else begin
                                stop_idx_q <= 1'b1;
                                brk_stop_q <= rxd_s;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Holding register and overrun
    // ------------------------------------------------------------------
    logic [D_W-1:0] hold_data;
    logic           hold_valid;
    logic           hold_perr;
    logic           hold_ferr;
    logic           hold_brk;
    logic           load;

    // A full register may still take the new word when it drains this cycle.
    assign load = frame_done && (!hold_valid || rx_out.out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            hold_perr  <= 1'b0;
            hold_ferr  <= 1'b0;
            hold_brk   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                hold_data  <= sh_q;
                hold_perr  <= perr_q;
                hold_ferr  <= ferr_fin;
                hold_brk   <= brk_fin;
                hold_valid <= 1'b1;
            end else if (hold_valid && rx_out.out_ready) begin
                hold_valid <= 1'b0;
            end

            if (frame_done && !load) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rx_out.out_data  = hold_data;
    assign rx_out.out_valid = hold_valid;
    assign rx_out.out_perr  = hold_perr;
    assign rx_out.out_ferr  = hold_ferr;
    assign rx_out.out_brk   = hold_brk;

endmodule

// File: tb/tb_uart_rx_v2.sv
// Directed testbench for uart_rx_v2: dvsr=3, B_TICK=16 -> 64 clocks per bit.
module tb_uart_rx_v2;

    localparam int BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] dvsr;
    logic [1:0]  par_mode;
    logic        stop2;
    logic        rxd;
    logic        overrun;
    logic        clr_ovr;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    // Accepted-word monitor
    int         cap_cnt = 0;
    logic [7:0] cap_data = '0;
    logic [2:0] cap_flags = '0;   // {perr, ferr, brk}

    uart_rx_v2_if #(.D_W(8)) bus ();

    uart_rx_v2 #(
        .D_W        (8),
        .B_TICK     (16),
        .DVSR_W     (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .dvsr    (dvsr),
        .par_mode(par_mode),
        .stop2   (stop2),
        .rxd     (rxd),
        .rx_out  (bus),
        .overrun (overrun),
        .clr_ovr (clr_ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            cap_data  <= bus.out_data;
            cap_flags <= {bus.out_perr, bus.out_ferr, bus.out_brk};
            cap_cnt   <= cap_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                              input logic s1, input logic s2, input int nstop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (has_par) bit_out(pbit);
        bit_out(s1);
        if (nstop == 2) bit_out(s2);
        idle_bits(2);
    endtask

    // Bounded wait for the monitor to reach exp_cnt accepted words.
    task automatic wait_cap(input string tag);
        int k;
        k = 0;
        while (cap_cnt != exp_cnt && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(tag, cap_cnt, exp_cnt);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dvsr = 16'd3; par_mode = 2'b00; stop2 = 1'b0;
        rxd = 1'b1; bus.out_ready = 1'b1; clr_ovr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_flags", {bus.out_perr, bus.out_ferr, bus.out_brk}, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0; en = 1'b1;
        idle_bits(2);

        // 8N1 basic word
        send_frame(8'hA5, 0, 1'b0, 1'b1, 1'b1, 1);
        exp_cnt++; wait_cap("a5_cnt");
        chk("a5_data", cap_data, 8'hA5);
        chk("a5_flags", cap_flags, 3'b000);

        // Even parity on 0x07 (three ones)
        par_mode = 2'b01;
        send_frame(8'h07, 1, 1'b0, 1'b1, 1'b1, 1);
        exp_cnt++; wait_cap("ev0_cnt");
        chk("ev0_data", cap_data, 8'h07);
        chk("ev0_flags", cap_flags, 3'b100);
        send_frame(8'h07, 1, 1'b1, 1'b1, 1'b1, 1);
        exp_cnt++; wait_cap("ev1_cnt");
        chk("ev1_flags", cap_flags, 3'b000);

        // Odd parity, opposite outcomes
        par_mode = 2'b10;
        send_frame(8'h07, 1, 1'b0, 1'b1, 1'b1, 1);
        exp_cnt++; wait_cap("od0_cnt");
        chk("od0_flags", cap_flags, 3'b000);
        send_frame(8'h07, 1, 1'b1, 1'b1, 1'b1, 1);
        exp_cnt++; wait_cap("od1_cnt");
        chk("od1_flags", cap_flags, 3'b100);

        // Two stop bits, second one low
        par_mode = 2'b00; stop2 = 1'b1;
        send_frame(8'h3C, 0, 1'b0, 1'b1, 1'b0, 2);
        exp_cnt++; wait_cap("fe_cnt");
        chk("fe_data", cap_data, 8'h3C);
        chk("fe_flags", cap_flags, 3'b010);
        // The line was still low when the frame ended, so a further frame may
        // legitimately start; let it flush and resynchronise the count.
        idle_bits(12);
        exp_cnt = cap_cnt;

        // Break: line low for 12 bit times
        rxd = 1'b0;
        repeat (12 * BIT_CLKS) @(posedge clk);
        #1;
        exp_cnt++;
        chk("brk_cnt", cap_cnt, exp_cnt);
        chk("brk_data", cap_data, 8'h00);
        chk("brk_flags", cap_flags, 3'b011);
        idle_bits(14);
        exp_cnt = cap_cnt;

        // Back-pressure and overrun
        stop2 = 1'b0; bus.out_ready = 1'b0;
        send_frame(8'h11, 0, 1'b0, 1'b1, 1'b1, 1);
        chk("bp1_valid", bus.out_valid, 1);
        chk("bp1_data", bus.out_data, 8'h11);
        chk("bp1_ovr", overrun, 0);
        send_frame(8'h22, 0, 1'b0, 1'b1, 1'b1, 1);
        chk("bp2_data", bus.out_data, 8'h11);
        chk("bp2_valid", bus.out_valid, 1);
        chk("bp2_ovr", overrun, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("bp_drain_valid", bus.out_valid, 0);
        chk("bp_drain_cnt", cap_cnt, exp_cnt);
        chk("bp_drain_data", cap_data, 8'h11);
        chk("bp_ovr_kept", overrun, 1);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        clr_ovr = 1'b0;
        chk("clr_ovr", overrun, 0);

        // Short low glitch must be rejected as a false start
        bus.out_ready = 1'b1;
        rxd = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        idle_bits(3);
        chk("glitch_cnt", cap_cnt, exp_cnt);
        send_frame(8'h5A, 0, 1'b0, 1'b1, 1'b1, 1);
        exp_cnt++; wait_cap("5a_cnt");
        chk("5a_data", cap_data, 8'h5A);
        chk("5a_flags", cap_flags, 3'b000);

        // Hold a word with overrun set, then reset in the middle of 0xFF
        bus.out_ready = 1'b0;
        send_frame(8'h3C, 0, 1'b0, 1'b1, 1'b1, 1);
        send_frame(8'h3C, 0, 1'b0, 1'b1, 1'b1, 1);
        chk("pre_rst_valid", bus.out_valid, 1);
        chk("pre_rst_ovr", overrun, 1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        #3 rst = 1'b1;
        #2;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_ovr", overrun, 0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        idle_bits(2);
        chk("post_rst_cnt", cap_cnt, exp_cnt);
        send_frame(8'h81, 0, 1'b0, 1'b1, 1'b1, 1);
        exp_cnt++; wait_cap("81_cnt");
        chk("81_data", cap_data, 8'h81);
        chk("81_flags", cap_flags, 3'b000);

        // Drop enable mid-frame
        bit_out(1'b0);
        bit_out(1'b1);
        en = 1'b0;
        rxd = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        en = 1'b1;
        idle_bits(12);
        chk("en_drop_cnt", cap_cnt, exp_cnt);
        chk("en_drop_valid", bus.out_valid, 0);
        send_frame(8'h42, 0, 1'b0, 1'b1, 1'b1, 1);
        exp_cnt++; wait_cap("42_cnt");
        chk("42_data", cap_data, 8'h42);
        chk("42_flags", cap_flags, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
